// File: rtl/timer_ctrl_master_if.sv
// rtl/timer_ctrl_master_if.sv - Avalon-MM bus between the timer master and the interval-timer slave
interface timer_ctrl_master_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_irq;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata,
    input  avm_irq
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata,
    output avm_irq
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// rtl/timer_ctrl_master.sv - Avalon-MM master that programs, services and snapshots the interval timer
module timer_ctrl_master #(
  parameter int TICK_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [31:0]          cfg_period,
  input  logic                 cfg_continuous,
  input  logic                 cfg_stop,
  input  logic                 snap_req,
  output logic                 busy,
  output logic                 tick,
  output logic [TICK_W-1:0]    tick_count,
  output logic [31:0]          snap_value,
  output logic                 snap_valid,
  timer_ctrl_master_if.master  avm
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_PL     = 4'd1;
  localparam logic [3:0] S_WR_PH     = 4'd2;
  localparam logic [3:0] S_WR_CTRL   = 4'd3;
  localparam logic [3:0] S_RUN       = 4'd4;
  localparam logic [3:0] S_ACK       = 4'd5;
  localparam logic [3:0] S_STOP      = 4'd6;
  localparam logic [3:0] S_SNAP_W    = 4'd7;
  localparam logic [3:0] S_SNAP_RL   = 4'd8;
  localparam logic [3:0] S_SNAP_RH   = 4'd9;
  localparam logic [3:0] S_SNAP_DONE = 4'd10;

  logic [3:0]  state, next_state;
  logic [31:0] period_q, period_n;
  logic        cont_q, cont_n;
  logic        start_ok;
  logic [2:0]  addr_n;
  logic        cs_n, wn_n;
  logic [15:0] wd_n;

  assign start_ok = (state == S_IDLE) && cfg_start;
  assign period_n = start_ok ? cfg_period : period_q;
  assign cont_n   = start_ok ? cfg_continuous : cont_q;

  // Sequencer: fixed three-write start, then RUN arbitrates stop > irq > snapshot.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (cfg_start) next_state = S_WR_PL;
      S_WR_PL:     next_state = S_WR_PH;
      S_WR_PH:     next_state = S_WR_CTRL;
      S_WR_CTRL:   next_state = S_RUN;
      S_RUN: begin
        if (cfg_stop)         next_state = S_STOP;
        else if (avm.avm_irq) next_state = S_ACK;
        else if (snap_req)    next_state = S_SNAP_W;
      end
      S_ACK:       next_state = cont_q ? S_RUN : S_IDLE;
      S_STOP:      next_state = S_IDLE;
      S_SNAP_W:    next_state = S_SNAP_RL;
      S_SNAP_RL:   next_state = S_SNAP_RH;
      S_SNAP_RH:   next_state = S_SNAP_DONE;
      S_SNAP_DONE: next_state = S_RUN;
      default:     next_state = S_IDLE;
    endcase
  end

  // Bus cycle for the state being entered, so registered outputs line up with that state.
  always_comb begin
    addr_n = 3'd0;
    cs_n   = 1'b0;
    wn_n   = 1'b1;
    wd_n   = 16'h0000;
    case (next_state)
      S_WR_PL:   begin addr_n = 3'd2; cs_n = 1'b1; wn_n = 1'b0; wd_n = period_n[15:0]; end
      S_WR_PH:   begin addr_n = 3'd3; cs_n = 1'b1; wn_n = 1'b0; wd_n = period_n[31:16]; end
      S_WR_CTRL: begin addr_n = 3'd1; cs_n = 1'b1; wn_n = 1'b0; wd_n = {13'd0, 1'b1, cont_n, 1'b1}; end
      S_ACK:     begin addr_n = 3'd0; cs_n = 1'b1; wn_n = 1'b0; end
      S_STOP:    begin addr_n = 3'd1; cs_n = 1'b1; wn_n = 1'b0; wd_n = 16'h0008; end
      S_SNAP_W:  begin addr_n = 3'd4; cs_n = 1'b1; wn_n = 1'b0; end
      S_SNAP_RL: begin addr_n = 3'd4; cs_n = 1'b1; end
      S_SNAP_RH: begin addr_n = 3'd5; cs_n = 1'b1; end
      default:   ;
    endcase
  end

  // State, latched configuration and registered Avalon outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      period_q           <= 32'd0;
      cont_q             <= 1'b0;
      busy               <= 1'b0;
      avm.avm_address    <= 3'd0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_writedata  <= 16'h0000;
    end else begin
      state              <= next_state;
      period_q           <= period_n;
      cont_q             <= cont_n;
      busy               <= (next_state != S_IDLE);
      avm.avm_address    <= addr_n;
      avm.avm_chipselect <= cs_n;
      avm.avm_write_n    <= wn_n;
      avm.avm_writedata  <= wd_n;
    end
  end

  // Tick pulse and count move together with the status-clear write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= (next_state == S_ACK);
      if (start_ok)
        tick_count <= '0;
      else if (next_state == S_ACK)
        tick_count <= tick_count + TICK_W'(1);
    end
  end

  // Snapshot halves arrive one cycle after each read address; snap_valid marks the high-half cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_value <= 32'd0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= (next_state == S_SNAP_DONE);
      if (state == S_SNAP_RH)
        snap_value[15:0] <= avm.avm_readdata;
      if (state == S_SNAP_DONE)
        snap_value[31:16] <= avm.avm_readdata;
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb/tb_timer_ctrl_master.sv - testbench for timer_ctrl_master with an interval-timer slave model
module tb_timer_ctrl_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_continuous, cfg_stop, snap_req;
  logic [31:0] cfg_period;
  logic        busy, tick, snap_valid;
  logic [31:0] tick_count, snap_value;

  timer_ctrl_master_if bus ();

  timer_ctrl_master #(.TICK_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .cfg_stop       (cfg_stop),
    .snap_req       (snap_req),
    .busy           (busy),
    .tick           (tick),
    .tick_count     (tick_count),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid),
    .avm            (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // interval-timer slave model
  logic [31:0] s_per, s_cnt, s_snap;
  logic        s_run, s_cont, s_ito, s_to, s_force;
  logic [31:0] snap_q[$];

  assign bus.avm_irq = s_to & s_ito;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s_per <= 0; s_cnt <= 0; s_snap <= 0;
      s_run <= 0; s_cont <= 0; s_ito <= 0; s_to <= 0;
      bus.avm_readdata <= 16'h0000;
    end else begin
      if (s_run) begin
        if (s_cnt == 0) begin
          s_to  <= 1'b1;
          s_cnt <= s_per;
          if (!s_cont) s_run <= 1'b0;
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end
      bus.avm_readdata <= 16'h0000;
      if (bus.avm_chipselect && !bus.avm_write_n) begin
        case (bus.avm_address)
          3'd0: s_to <= 1'b0;
          3'd1: begin
            s_ito  <= bus.avm_writedata[0];
            s_cont <= bus.avm_writedata[1];
            if (bus.avm_writedata[2]) s_run <= 1'b1;
            if (bus.avm_writedata[3]) s_run <= 1'b0;
          end
          3'd2: begin
            s_per[15:0] <= bus.avm_writedata;
            s_cnt <= {s_per[31:16], bus.avm_writedata};
            s_run <= 1'b0;
          end
          3'd3: begin
            s_per[31:16] <= bus.avm_writedata;
            s_cnt <= {bus.avm_writedata, s_per[15:0]};
            s_run <= 1'b0;
          end
          3'd4: begin
            s_snap <= s_force ? 32'h0002_0005 : s_cnt;
            snap_q.push_back(s_force ? 32'h0002_0005 : s_cnt);
          end
          default: ;
        endcase
      end else if (bus.avm_chipselect) begin
        case (bus.avm_address)
          3'd0: bus.avm_readdata <= {15'd0, s_to};
          3'd4: bus.avm_readdata <= s_snap[15:0];
          3'd5: bus.avm_readdata <= s_snap[31:16];
          default: bus.avm_readdata <= 16'h0000;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_bus(input string name, input logic wr, input logic [2:0] addr, input logic [15:0] data);
    chk({name, "_cs"}, {31'd0, bus.avm_chipselect}, 1);
    chk({name, "_write_n"}, {31'd0, bus.avm_write_n}, {31'd0, !wr});
    chk({name, "_addr"}, {29'd0, bus.avm_address}, {29'd0, addr});
    if (wr) chk({name, "_data"}, {16'd0, bus.avm_writedata}, {16'd0, data});
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 0);
    chk({name, "_tick"}, {31'd0, tick}, 0);
    chk({name, "_tick_count"}, tick_count, 0);
    chk({name, "_snap_value"}, snap_value, 0);
    chk({name, "_snap_valid"}, {31'd0, snap_valid}, 0);
    chk({name, "_cs"}, {31'd0, bus.avm_chipselect}, 0);
    chk({name, "_write_n"}, {31'd0, bus.avm_write_n}, 1);
    chk({name, "_addr"}, {29'd0, bus.avm_address}, 0);
    chk({name, "_wdata"}, {16'd0, bus.avm_writedata}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_start = 0; cfg_stop = 0; snap_req = 0; cfg_continuous = 0; cfg_period = 0; s_force = 0;
    snap_q.delete();
    step(); step();
    reset = 1'b0;
    step();
  endtask

  // drives cfg_start in the current cycle (cycle 0); returns at cycle 1
  task automatic start(input logic [31:0] p, input logic c);
    cfg_start = 1'b1; cfg_period = p; cfg_continuous = c;
    step();
    cfg_start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] period;
    logic        cont;
    logic [15:0] pl;
    logic [15:0] ph;
    logic [15:0] ctrl;
  } start_vec_t;

  start_vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, acks, last, c, post_bus;
    logic spacing_ok, seen_tick;

    vecs[0] = '{32'h0001_1387, 1'b1, 16'h1387, 16'h0001, 16'h0007};
    vecs[1] = '{32'hDEAD_BEEF, 1'b0, 16'hBEEF, 16'hDEAD, 16'h0005};
    vecs[2] = '{32'h0000_0000, 1'b1, 16'h0000, 16'h0000, 16'h0007};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0005};

    do_reset();
    chk_reset_outputs("reset");

    // start sequence vectors, each ended with a stop
    foreach (vecs[i]) begin
      do_reset();
      start(vecs[i].period, vecs[i].cont);
      chk_bus("vec_wr_pl", 1'b1, 3'd2, vecs[i].pl);
      chk("vec_busy", {31'd0, busy}, 1);
      step();
      chk_bus("vec_wr_ph", 1'b1, 3'd3, vecs[i].ph);
      step();
      chk_bus("vec_wr_ctrl", 1'b1, 3'd1, vecs[i].ctrl);
      step();
      chk("vec_run_idle_bus", {31'd0, bus.avm_chipselect}, 0);
      cfg_stop = 1'b1;
      step();
      cfg_stop = 1'b0;
      chk_bus("vec_stop", 1'b1, 3'd1, 16'h0008);
      step();
      chk("vec_busy_after_stop", {31'd0, busy}, 0);
      chk("vec_cs_after_stop", {31'd0, bus.avm_chipselect}, 0);
    end

    // continuous, period 9: five ticks ten cycles apart
    do_reset();
    start(32'd9, 1'b1);
    ticks = 0; acks = 0; last = -1; c = 1; spacing_ok = 1'b1;
    while (ticks < 5 && c < 200) begin
      if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 3'd0) acks++;
      if (tick) begin
        if (last >= 0 && c - last != 10) spacing_ok = 1'b0;
        last = c;
        ticks++;
      end
      step();
      c++;
    end
    chk("cont_ticks_seen", ticks, 5);
    chk("cont_tick_count", tick_count, 5);
    chk("cont_status_writes", acks, 5);
    chk("cont_tick_spacing", {31'd0, spacing_ok}, 1);

    // one-shot, period 4: single ack then silence
    do_reset();
    start(32'd4, 1'b0);
    acks = 0; post_bus = 0; seen_tick = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 3'd0) acks++;
      if (seen_tick && bus.avm_chipselect) post_bus++;
      if (tick) seen_tick = 1'b1;
      step();
    end
    chk("oneshot_acks", acks, 1);
    chk("oneshot_tick_count", tick_count, 1);
    chk("oneshot_busy", {31'd0, busy}, 0);
    chk("oneshot_bus_after_ack", post_bus, 0);

    // snapshot with forced counter value; cfg_start in RUN ignored
    do_reset();
    start(32'd1000, 1'b1);
    step(); step(); step();
    cfg_start = 1'b1; cfg_period = 32'd3; cfg_continuous = 1'b0;
    step();
    cfg_start = 1'b0;
    chk("start_while_busy_cs", {31'd0, bus.avm_chipselect}, 0);
    chk("start_while_busy_busy", {31'd0, busy}, 1);
    s_force = 1'b1;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk_bus("snap_w", 1'b1, 3'd4, 16'h0000);
    step();
    chk_bus("snap_rl", 1'b0, 3'd4, 16'h0000);
    chk("snap_valid_n2", {31'd0, snap_valid}, 0);
    step();
    chk_bus("snap_rh", 1'b0, 3'd5, 16'h0000);
    chk("snap_valid_n3", {31'd0, snap_valid}, 0);
    step();
    chk("snap_valid_n4", {31'd0, snap_valid}, 1);
    step();
    chk("snap_value", snap_value, 32'h0002_0005);
    chk("snap_valid_n5", {31'd0, snap_valid}, 0);
    s_force = 1'b0;

    // stop and irq in the same RUN cycle: stop wins
    do_reset();
    start(32'd5, 1'b1);
    c = 0;
    while (!bus.avm_irq && c < 50) begin step(); c++; end
    chk("stop_irq_seen", {31'd0, bus.avm_irq}, 1);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk_bus("stop_irq_write", 1'b1, 3'd1, 16'h0008);
    chk("stop_irq_tick", {31'd0, tick}, 0);
    step();
    chk("stop_irq_busy", {31'd0, busy}, 0);
    chk("stop_irq_tick_count", tick_count, 0);
    chk("stop_irq_cs", {31'd0, bus.avm_chipselect}, 0);

    // reset during WR_PH, then a clean restart
    do_reset();
    start(32'h1234_5678, 1'b1);
    step();
    chk_bus("rst_pre_wr_ph", 1'b1, 3'd3, 16'h1234);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    step();
    reset = 1'b0;
    step();
    chk("rst_no_access", {31'd0, bus.avm_chipselect}, 0);
    start(32'h0000_00AB, 1'b0);
    chk_bus("rst_restart_pl", 1'b1, 3'd2, 16'h00AB);
    step();
    chk_bus("rst_restart_ph", 1'b1, 3'd3, 16'h0000);
    step();
    chk_bus("rst_restart_ctrl", 1'b1, 3'd1, 16'h0005);

    // randomized snapshot requests against an event-timing model
    for (int r = 0; r < 3; r++) begin
      int p, free_at, tick_due, snap_due, exp_cnt;
      p = $urandom_range(6, 20);
      free_at = 4; tick_due = -1; snap_due = -1; exp_cnt = 0;
      do_reset();
      start(p, 1'b1);
      for (int cc = 1; cc < 250; cc++) begin
        chk("rnd_tick", {31'd0, tick}, {31'd0, cc == tick_due});
        chk("rnd_snap_valid", {31'd0, snap_valid}, {31'd0, cc == snap_due});
        if (cc == snap_due + 1) begin
          chk("rnd_snap_pending", {31'd0, snap_q.size() != 0}, 1);
          if (snap_q.size() != 0) chk("rnd_snap_value", snap_value, snap_q.pop_front());
        end
        snap_req = ($urandom_range(0, 7) == 0);
        if (cc >= free_at) begin
          if (bus.avm_irq) begin
            tick_due = cc + 1; free_at = cc + 2; exp_cnt++;
          end else if (snap_req) begin
            snap_due = cc + 4; free_at = cc + 5;
          end
        end
        step();
      end
      snap_req = 1'b0;
      chk("rnd_tick_count", tick_count, exp_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
